std_seq_mem_d1: RTL and testbench

STD_SEQ_MEM_D1 -- requirements
Module: std_seq_mem_d1

---
 rtl/std_seq_mem_stage.sv | 23 ++
 rtl/std_seq_mem_d1.sv | 112 +++++++++++
 tb/tb_std_seq_mem_d1.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/std_seq_mem_stage.sv
// One pipeline stage for the sequential memory: resettable valid bit plus an
// unreset payload register.
module std_seq_mem_stage #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_d,
  input  logic [WIDTH-1:0] payload_d,
  output logic             valid_q,
  output logic [WIDTH-1:0] payload_q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
    payload_q <= payload_d;
  end

endmodule

// File: rtl/std_seq_mem_d1.sv
// Single-port sequential memory with a fixed LATENCY-cycle response pipeline,
// read-before-write semantics and out-of-bounds flagging.
module std_seq_mem_d1 #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SIZE     = 16,
  parameter int unsigned IDX_SIZE = 4,
  parameter int unsigned LATENCY  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_SIZE-1:0] addr0,
  input  logic [WIDTH-1:0]    write_data,
  input  logic                write_en,
  input  logic                read_en,
  output logic [WIDTH-1:0]    read_data,
  output logic                done,
  output logic                oob
);

  localparam bit LatencyOk = (LATENCY >= 1) && (LATENCY <= 4);
  localparam bit SizeOk    = (SIZE >= 1) && (SIZE <= 2 ** IDX_SIZE);

  if (!LatencyOk) begin : g_bad_latency
    $error("std_seq_mem_d1: LATENCY must be in 1..4");
  end
  if (!SizeOk) begin : g_bad_size
    $error("std_seq_mem_d1: SIZE must be in 1..2**IDX_SIZE");
  end

  typedef struct packed {
    logic             is_read;
    logic             oob;
    logic [WIDTH-1:0] data;
  } payload_t;

  localparam int unsigned PayloadW = $bits(payload_t);

  logic [WIDTH-1:0] mem [SIZE];

  logic          accept;
  logic          in_bounds;
  payload_t      entry_d;
  payload_t      tail;
  logic [LATENCY-1:0]  chain_valid;
  logic [PayloadW-1:0] chain_payload [LATENCY];

  logic             done_q;
  logic             oob_q;
  logic [WIDTH-1:0] read_data_q;

  assign accept    = (read_en | write_en) & ~reset;
  assign in_bounds = 32'(addr0) < SIZE;

  // Combinational read of the pre-edge array gives read-before-write for free.
  always_comb begin
    entry_d         = '0;
    entry_d.is_read = read_en;
    entry_d.oob     = ~in_bounds;
    entry_d.data    = (read_en && in_bounds) ? mem[addr0] : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset && write_en && in_bounds) begin
      mem[addr0] <= write_data;
    end
  end

  assign chain_valid[0]   = accept;
  assign chain_payload[0] = entry_d;

  for (genvar i = 1; i < LATENCY; i++) begin : g_stage
    std_seq_mem_stage #(
      .WIDTH(PayloadW)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .valid_d  (chain_valid[i-1]),
      .payload_d(chain_payload[i-1]),
      .valid_q  (chain_valid[i]),
      .payload_q(chain_payload[i])
    );
  end

  assign tail = payload_t'(chain_payload[LATENCY-1]);

  // Final stage: read_data only loads on a completing read, so it holds
  // across write-only responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q      <= 1'b0;
      oob_q       <= 1'b0;
      read_data_q <= '0;
    end else begin
      done_q <= chain_valid[LATENCY-1];
      oob_q  <= chain_valid[LATENCY-1] & tail.oob;
      if (chain_valid[LATENCY-1] && tail.is_read) begin
        read_data_q <= tail.data;
      end
    end
  end

  assign done      = done_q & ~reset;
  assign oob       = oob_q & ~reset;
  assign read_data = reset ? '0 : read_data_q;

  always_comb begin
    if (accept && !in_bounds) begin
      $warning("std_seq_mem_d1: addr0 %0d >= SIZE %0d", addr0, SIZE);
    end
  end

endmodule

// File: tb/tb_std_seq_mem_d1.sv
// Drives four instances (LATENCY 1..4) with one shared stimulus stream and
// checks each against a history-based model of accepted requests.
module tb_std_seq_mem_d1;

  localparam int unsigned Size = 10;
  localparam int MaxEdges = 2048;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  addr0;
  logic [31:0] write_data;
  logic        write_en;
  logic        read_en;

  logic [31:0] rdata_w [1:4];
  logic [4:1]  done_w;
  logic [4:1]  oob_w;

  int errors = 0;
  int checks = 0;

  // Per-edge history of what the spec says each request produces.
  bit          acc_h [MaxEdges];
  bit          rd_h  [MaxEdges];
  bit          oob_h [MaxEdges];
  bit          rst_h [MaxEdges];
  logic [31:0] dat_h [MaxEdges];
  logic [31:0] ref_mem [Size];
  logic [31:0] rd_model [1:4];
  int          edges = 0;

  always #5 clk = ~clk;

  for (genvar l = 1; l <= 4; l++) begin : g_dut
    std_seq_mem_d1 #(
      .WIDTH   (32),
      .SIZE    (Size),
      .IDX_SIZE(4),
      .LATENCY (l)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .addr0     (addr0),
      .write_data(write_data),
      .write_en  (write_en),
      .read_en   (read_en),
      .read_data (rdata_w[l]),
      .done      (done_w[l]),
      .oob       (oob_w[l])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Request accepted at edge m-lat+1 completes after edge m unless a reset edge intervened.
  function automatic bit exp_done_at(input int m, input int lat);
    int e0 = m - lat + 1;
    if (e0 < 0) return 1'b0;
    if (!acc_h[e0]) return 1'b0;
    for (int k = e0 + 1; k <= m; k++) begin
      if (rst_h[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic step(input bit r, input bit we, input bit re, input logic [3:0] a,
                      input logic [31:0] wd);
    reset      = r;
    write_en   = we;
    read_en    = re;
    addr0      = a;
    write_data = wd;
    @(negedge clk);
    for (int l = 1; l <= 4; l++) begin
      bit d;
      bit o;
      d = !r && exp_done_at(edges - 1, l);
      o = d && oob_h[edges - l];
      check_eq($sformatf("done L%0d e%0d", l, edges), {31'b0, done_w[l]}, {31'b0, d});
      check_eq($sformatf("oob L%0d e%0d", l, edges), {31'b0, oob_w[l]}, {31'b0, o});
      check_eq($sformatf("read_data L%0d e%0d", l, edges), rdata_w[l],
               r ? 32'h0 : rd_model[l]);
    end
    @(posedge clk);
    rst_h[edges] = r;
    acc_h[edges] = !r && (we || re);
    rd_h[edges]  = re;
    oob_h[edges] = 32'(a) >= Size;
    dat_h[edges] = (re && 32'(a) < Size) ? ref_mem[a] : 32'h0;
    if (acc_h[edges] && we && 32'(a) < Size) ref_mem[a] = wd;
    for (int l = 1; l <= 4; l++) begin
      if (r) rd_model[l] = 32'h0;
      else if (exp_done_at(edges, l) && rd_h[edges - l + 1]) rd_model[l] = dat_h[edges - l + 1];
    end
    edges++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int l = 1; l <= 4; l++) rd_model[l] = 32'h0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 4'd0, 32'h0);
    // Fill 0..9 with 100..109, then stream reads back-to-back.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 4'(i), 32'(100 + i));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 4'(i), 32'h0);
    idle(5);
    step(1'b0, 1'b1, 1'b0, 4'd3, 32'hDEADBEEF);
    step(1'b0, 1'b0, 1'b1, 4'd3, 32'h0);
    idle(5);
    step(1'b0, 1'b1, 1'b0, 4'd5, 32'd7);
    step(1'b0, 1'b1, 1'b1, 4'd5, 32'd9);
    step(1'b0, 1'b0, 1'b1, 4'd5, 32'h0);
    idle(5);
    step(1'b0, 1'b1, 1'b0, 4'd12, 32'h55);
    step(1'b0, 1'b0, 1'b1, 4'd12, 32'h0);
    idle(5);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 4'(i), 32'h0);
    idle(5);
    // Reset with reads in flight.
    step(1'b0, 1'b0, 1'b1, 4'd1, 32'h0);
    step(1'b0, 1'b0, 1'b1, 4'd2, 32'h0);
    step(1'b1, 1'b1, 1'b1, 4'd4, 32'hBAD0BAD0);
    idle(6);
    step(1'b0, 1'b0, 1'b1, 4'd1, 32'h0);
    step(1'b0, 1'b0, 1'b1, 4'd4, 32'h0);
    idle(5);
    step(1'b0, 1'b1, 1'b0, 4'd6, 32'h1234);
    step(1'b0, 1'b0, 1'b1, 4'd6, 32'h0);
    step(1'b0, 1'b1, 1'b0, 4'd7, 32'hCAFE);
    idle(6);
    for (int i = 0; i < 400; i++) begin
      bit r;
      int op;
      logic [3:0] a;
      r  = ($urandom_range(0, 49) == 0);
      op = $urandom_range(0, 3);
      a  = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      step(r, op[1], op[0], a, $urandom);
    end
    idle(6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
